// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, I-cache request/drop FSM,
// direct-mapped BTB with 2-bit saturating counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16,
  parameter int          DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              dcache_stall,
  input  logic              predict_fail,
  input  logic [DATA_W-1:0] redirect_pc,
  input  logic              upd_valid,
  input  logic [DATA_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [DATA_W-1:0] upd_target,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              icache_stall,
  output logic [DATA_W-1:0] inst_out,
  output logic [DATA_W-1:0] pc_out,
  output logic              predict_out,
  output logic [DATA_W-1:0] predict_pc_out
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = DATA_W - IDX - 2;

  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   pc;
  logic [DATA_W-1:0]   drop_addr;

  logic                btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]    btb_tag    [BTB_ENTRIES];
  logic [DATA_W-1:0]   btb_target [BTB_ENTRIES];
  logic [1:0]          btb_ctr    [BTB_ENTRIES];

  logic [IDX-1:0]      rd_idx;
  logic [TAG_W-1:0]    rd_tag;
  logic                btb_hit;
  logic [DATA_W-1:0]   pc_plus4;

  logic [IDX-1:0]      wr_idx;
  logic [TAG_W-1:0]    wr_tag;
  logic                wr_hit;

  logic                fetch_done;
  logic                unused_upd_bits;

  assign unused_upd_bits = ^upd_pc[1:0];

  // BTB read port and prediction for the current PC
  assign rd_idx   = pc[IDX+1:2];
  assign rd_tag   = pc[DATA_W-1:IDX+2];
  assign btb_hit  = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
  assign pc_plus4 = pc + DATA_W'(4);

  assign predict_out    = btb_hit && btb_ctr[rd_idx][1]
                          && (state == FETCH);
  assign predict_pc_out = predict_out ? btb_target[rd_idx]
                                      : pc_plus4;

  // Training port lookup
  assign wr_idx = upd_pc[IDX+1:2];
  assign wr_tag = upd_pc[DATA_W-1:IDX+2];
  assign wr_hit = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);

  // Cache interface; DROP keeps the abandoned address on the bus
  assign imem_req     = 1'b1;
  assign imem_addr    = (state == DROP) ? drop_addr : pc;
  assign fetch_done   = (state == FETCH) && imem_ready;
  assign icache_stall = ((state == FETCH) && !imem_ready)
                        || (state == DROP);

  assign inst_out = fetch_done ? imem_rdata : '0;
  assign pc_out   = pc;

  // PC and fetch FSM: reset > redirect > drop > stall > advance
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC[DATA_W-1:0];
      state     <= FETCH;
      drop_addr <= '0;
    end else if (predict_fail) begin
      pc <= redirect_pc;
      if ((state == FETCH) && !imem_ready) begin
        drop_addr <= pc;
        state     <= DROP;
      end
    end else if (state == DROP) begin
      if (imem_ready) begin
        state <= FETCH;
      end
    end else if (dcache_stall || hold || icache_stall) begin
      pc <= pc;
    end else begin
      pc <= predict_pc_out;
    end
  end

  // BTB training from branch resolution
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        btb_ctr[i]   <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        if (wr_hit) begin
          if (btb_ctr[wr_idx] != 2'b11) begin
            btb_ctr[wr_idx] <= btb_ctr[wr_idx] + 2'b01;
          end
          btb_target[wr_idx] <= upd_target;
        end else begin
          btb_valid[wr_idx]  <= 1'b1;
          btb_tag[wr_idx]    <= wr_tag;
          btb_target[wr_idx] <= upd_target;
          btb_ctr[wr_idx]    <= 2'b10;
        end
      end else if (wr_hit) begin
        if (btb_ctr[wr_idx] != 2'b00) begin
          btb_ctr[wr_idx] <= btb_ctr[wr_idx] - 2'b01;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: vector table plus hand sequences,
// forwarded instructions checked through a scoreboard queue.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        dcache_stall;
  logic        predict_fail;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        icache_stall;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        predict_out;
  logic [31:0] predict_pc_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        hld;
    logic        dst;
    logic        pf;
    logic [31:0] rpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        est;
    logic        epr;
    logic [31:0] eppc;
    logic        fwd;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[$];

  if_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .hold          (hold),
    .dcache_stall  (dcache_stall),
    .predict_fail  (predict_fail),
    .redirect_pc   (redirect_pc),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .icache_stall  (icache_stall),
    .inst_out      (inst_out),
    .pc_out        (pc_out),
    .predict_out   (predict_out),
    .predict_pc_out(predict_pc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic vec_t mk(
    input logic rd, input logic [31:0] data,
    input logic hld, input logic dst,
    input logic pf, input logic [31:0] rpc,
    input logic uv, input logic [31:0] upc,
    input logic ut, input logic [31:0] utgt,
    input logic [31:0] epc, input logic [31:0] eaddr,
    input logic est, input logic epr,
    input logic [31:0] eppc, input logic fwd);
    vec_t x;
    x.rd = rd;   x.data = data; x.hld = hld; x.dst = dst;
    x.pf = pf;   x.rpc = rpc;   x.uv = uv;   x.upc = upc;
    x.ut = ut;   x.utgt = utgt; x.epc = epc; x.eaddr = eaddr;
    x.est = est; x.epr = epr;   x.eppc = eppc; x.fwd = fwd;
    return x;
  endfunction

  // Drive one cycle of stimulus, check, then step the clock
  task automatic apply(input vec_t x);
    exp_t e;
    imem_ready   = x.rd;
    imem_rdata   = x.data;
    hold         = x.hld;
    dcache_stall = x.dst;
    predict_fail = x.pf;
    redirect_pc  = x.rpc;
    upd_valid    = x.uv;
    upd_pc       = x.upc;
    upd_taken    = x.ut;
    upd_target   = x.utgt;
    #1;
    chk("req", {31'b0, imem_req}, 32'd1);
    chk("pc_out", pc_out, x.epc);
    chk("imem_addr", imem_addr, x.eaddr);
    chk("icache_stall", {31'b0, icache_stall}, {31'b0, x.est});
    chk("predict_out", {31'b0, predict_out}, {31'b0, x.epr});
    chk("predict_pc", predict_pc_out, x.eppc);
    if (x.fwd) begin
      e.pc   = x.epc;
      e.inst = x.data;
      sbq.push_back(e);
    end else begin
      chk("inst_zero", inst_out, 32'd0);
    end
    if (!icache_stall) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected got %h want none", inst_out);
      end else begin
        e = sbq.pop_front();
        chk("sb_pc", pc_out, e.pc);
        chk("sb_inst", inst_out, e.inst);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; hold = 0; dcache_stall = 0; predict_fail = 0;
    redirect_pc = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0;
    upd_target = 0; imem_ready = 0; imem_rdata = 32'hBAD0_0BAD;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_stall", {31'b0, icache_stall}, 32'd1);
    chk("rst_pred", {31'b0, predict_out}, 32'd0);

    // rd data hld dst pf rpc uv upc ut utgt | epc addr st pr ppc fwd
    tbl.push_back(mk(1, 32'hA0, 0,0, 0,0, 0,0,0,0,
                     32'h0, 32'h0, 0, 0, 32'h4, 1));
    tbl.push_back(mk(1, 32'hA1, 0,0, 0,0, 0,0,0,0,
                     32'h4, 32'h4, 0, 0, 32'h8, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 32'hBAD, 0,0, 0,0, 0,0,0,0,
                       32'h8, 32'h8, 1, 0, 32'hC, 0));
    tbl.push_back(mk(1, 32'hA2, 0,0, 0,0, 0,0,0,0,
                     32'h8, 32'h8, 0, 0, 32'hC, 1));
    tbl.push_back(mk(1, 32'hA3, 0,0, 0,0, 0,0,0,0,
                     32'hC, 32'hC, 0, 0, 32'h10, 1));
    // train 0x10 -> 0x40 while stalled; same-cycle lookup is stale
    tbl.push_back(mk(0, 32'hBAD, 0,0, 0,0, 1,32'h10,1,32'h40,
                     32'h10, 32'h10, 1, 0, 32'h14, 0));
    tbl.push_back(mk(1, 32'hA4, 0,0, 0,0, 0,0,0,0,
                     32'h10, 32'h10, 0, 1, 32'h40, 1));
    tbl.push_back(mk(1, 32'hA5, 0,0, 0,0, 0,0,0,0,
                     32'h40, 32'h40, 0, 0, 32'h44, 1));
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(0, 32'hBAD, 0,0, 0,0, 1,32'h10,0,0,
                       32'h44, 32'h44, 1, 0, 32'h48, 0));
    tbl.push_back(mk(1, 32'hA6, 0,0, 1,32'h10, 0,0,0,0,
                     32'h44, 32'h44, 0, 0, 32'h48, 1));
    tbl.push_back(mk(1, 32'hA7, 0,0, 0,0, 0,0,0,0,
                     32'h10, 32'h10, 0, 0, 32'h14, 1));
    // saturation: 4 taken then 1 not-taken on 0x20
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 32'hBAD, 0,0, 0,0, 1,32'h20,1,32'h100,
                       32'h14, 32'h14, 1, 0, 32'h18, 0));
    tbl.push_back(mk(0, 32'hBAD, 0,0, 0,0, 1,32'h20,0,0,
                     32'h14, 32'h14, 1, 0, 32'h18, 0));
    tbl.push_back(mk(1, 32'hA8, 0,0, 1,32'h20, 0,0,0,0,
                     32'h14, 32'h14, 0, 0, 32'h18, 1));
    tbl.push_back(mk(1, 32'hA9, 0,0, 0,0, 0,0,0,0,
                     32'h20, 32'h20, 0, 1, 32'h100, 1));
    // redirect during a miss at 0x20 -> DROP
    tbl.push_back(mk(1, 32'hAA, 0,0, 1,32'h20, 0,0,0,0,
                     32'h100, 32'h100, 0, 0, 32'h104, 1));
    tbl.push_back(mk(0, 32'hBAD, 0,0, 1,32'h80, 0,0,0,0,
                     32'h20, 32'h20, 1, 1, 32'h100, 0));
    tbl.push_back(mk(0, 32'hBAD, 0,0, 0,0, 0,0,0,0,
                     32'h80, 32'h20, 1, 0, 32'h84, 0));
    tbl.push_back(mk(1, 32'hDEAD, 0,0, 0,0, 0,0,0,0,
                     32'h80, 32'h20, 1, 0, 32'h84, 0));
    tbl.push_back(mk(1, 32'hAB, 0,0, 0,0, 0,0,0,0,
                     32'h80, 32'h80, 0, 0, 32'h84, 1));

    foreach (tbl[i]) apply(tbl[i]);

    // hold and dcache_stall at 0x24, redirect beating dcache_stall
    apply(mk(1, 32'hAC, 0,0, 1,32'h24, 0,0,0,0,
             32'h84, 32'h84, 0, 0, 32'h88, 1));
    for (int i = 0; i < 2; i++)
      apply(mk(1, 32'hAD, 1,0, 0,0, 0,0,0,0,
               32'h24, 32'h24, 0, 0, 32'h28, 1));
    for (int i = 0; i < 2; i++)
      apply(mk(1, 32'hAE, 0,1, 0,0, 0,0,0,0,
               32'h24, 32'h24, 0, 0, 32'h28, 1));
    apply(mk(1, 32'hAF, 0,1, 1,32'h60, 0,0,0,0,
             32'h24, 32'h24, 0, 0, 32'h28, 1));
    apply(mk(1, 32'hB0, 0,0, 0,0, 0,0,0,0,
             32'h60, 32'h60, 0, 0, 32'h64, 1));

    // PC wrap
    apply(mk(1, 32'hB1, 0,0, 1,32'hFFFF_FFFC, 0,0,0,0,
             32'h64, 32'h64, 0, 0, 32'h68, 1));
    apply(mk(1, 32'hB2, 0,0, 0,0, 0,0,0,0,
             32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 32'h0, 1));
    apply(mk(1, 32'hB3, 0,0, 0,0, 0,0,0,0,
             32'h0, 32'h0, 0, 0, 32'h4, 1));

    // reset while dropping an abandoned miss
    apply(mk(1, 32'hB4, 0,0, 1,32'h30, 0,0,0,0,
             32'h4, 32'h4, 0, 0, 32'h8, 1));
    apply(mk(0, 32'hBAD, 0,0, 1,32'h50, 0,0,0,0,
             32'h30, 32'h30, 1, 0, 32'h34, 0));
    rst = 1'b1; predict_fail = 0; imem_ready = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(mk(0, 32'hBAD, 0,0, 0,0, 0,0,0,0,
             32'h0, 32'h0, 1, 0, 32'h4, 0));
    apply(mk(1, 32'hB5, 0,0, 1,32'h20, 0,0,0,0,
             32'h0, 32'h0, 0, 0, 32'h4, 1));
    apply(mk(1, 32'hB6, 0,0, 0,0, 0,0,0,0,
             32'h20, 32'h20, 0, 0, 32'h24, 1));

    chk("sb_empty", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage: owns the PC, issues requests to the instruction cache, and runs a direct-mapped BTB with 2-bit counters.
- Produces the fetched instruction, its PC and the branch prediction (taken flag and target) that the IF/ID register latches.
- Redirects to the branch unit's corrected PC on predict_fail and trains the BTB from branch-resolution updates.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BTB_ENTRIES, 16, number of BTB entries; power of two, at least 2.
- DATA_W, 32, width of PC and instruction.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  load-use hazard hold; the same signal that drives the IF/ID write-hold input.
- dcache_stall  in  1  data-cache miss stall.
- predict_fail  in  1  branch mispredict; redirect fetch.
- redirect_pc  in  DATA_W  correct next PC, valid when predict_fail=1.
- upd_valid  in  1  branch-resolution training strobe.
- upd_pc  in  DATA_W  PC of the resolved branch.
- upd_taken  in  1  resolved branch direction.
- upd_target  in  DATA_W  resolved taken target.
- imem_req  out  1  instruction-cache request.
- imem_addr  out  DATA_W  request address.
- imem_ready  in  1  response valid this cycle; may be asserted in the same cycle as the request (hit).
- imem_rdata  in  DATA_W  instruction word, valid when imem_ready=1.
- icache_stall  out  1  fetch waiting on the cache.
- inst_out  out  DATA_W  instruction to IF/ID.
- pc_out  out  DATA_W  PC to IF/ID.
- predict_out  out  1  predicted taken.
- predict_pc_out  out  DATA_W  predicted next PC.

Behaviour:
- Cache protocol:
  - imem_addr must stay stable while imem_req=1 and imem_ready=0.
  - A request completes in the cycle where imem_req=1 and imem_ready=1.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - DROP: imem_req=1, imem_addr=drop_addr. Consumes the response of an abandoned request.
- Reset (rst=1 in any state):
  - pc<=RESET_PC, state<=FETCH.
  - All BTB valid bits cleared; all counters set to 2'b01.
  - Registered outputs take effect next cycle; no request is held across reset.
- icache_stall = (state==FETCH && !imem_ready) || state==DROP.
- Outputs, combinational:
  - inst_out = imem_rdata when state==FETCH && imem_ready, else 0.
  - pc_out = pc.
  - predict_out = btb_hit && ctr[1] && state==FETCH.
  - predict_pc_out = btb target when predict_out=1, else pc+4.
- BTB lookup:
  - index = pc[IDX+1:2] with IDX=log2(BTB_ENTRIES); tag = pc[DATA_W-1:IDX+2].
  - btb_hit = valid[index] && tag matches.
- Next-PC priority:
  1. rst.
  2. predict_fail: pc<=redirect_pc.
     - If state==FETCH && !imem_ready: drop_addr<=pc, state<=DROP.
     - Redirect beats dcache_stall, hold and icache_stall.
  3. state==DROP: pc holds. On imem_ready the response is discarded and state<=FETCH.
  4. dcache_stall || hold || icache_stall: pc holds.
  5. Otherwise pc<=predict_pc_out.
- predict_fail while in DROP: pc<=redirect_pc, remain in DROP, drop_addr unchanged.
- PC arithmetic is modulo 2^DATA_W: pc+4 wraps from 32'hFFFF_FFFC to 0.
- BTB update (upd_valid=1):
  - Taken, entry hit: ctr saturating +1, target<=upd_target.
  - Taken, entry miss: allocate (valid=1, tag, target), ctr=2'b10.
  - Not taken, entry hit: ctr saturating -1; entry stays valid.
  - Not taken, entry miss: no change.
- Update and lookup at the same index in the same cycle: lookup uses the pre-update contents; the write is visible next cycle.

Test Plan:
- Reset, always-hit cache: pc_out sequence 0,4,8,12 on consecutive cycles; inst_out equals imem_rdata each cycle; predict_out=0.
- Miss: imem_ready low for 3 cycles at pc=8 -> icache_stall=1 and imem_addr=8 held for 3 cycles; pc advances to 12 in the cycle after ready.
- Train upd_pc=0x10, taken, target 0x40, then fetch 0x10 -> predict_out=1, predict_pc_out=0x40, next pc_out=0x40. Two not-taken updates afterwards -> predict_out=0 at 0x10.
- predict_fail with redirect_pc=0x80 during a miss at 0x20 -> imem_addr stays 0x20 until ready; that response is not forwarded (inst_out=0); the next request is 0x80.
- hold=1 or dcache_stall=1 for 2 cycles at pc=0x24 -> pc_out stays 0x24. predict_fail in the same cycle as dcache_stall -> pc_out=redirect_pc next cycle.
- Counter saturation: 4 taken updates then 1 not-taken -> still predicted taken. Wrap: pc 32'hFFFF_FFFC -> 0. rst asserted mid-miss -> pc=RESET_PC and state FETCH.
